axis_sample_packer: RTL and testbench
=====================================

// Module: axis_sample_packer
// PURPOSE
//  Upstream feeder for the DMA stream-to-memory write path (DMA s_axis slave).
//  Packs narrow DSP/ADC samples (no backpressure) into AXI_WIDTH words, buffers them in a small FIFO,
//  and presents an AXI4-stream master carrying exactly words_cfg+1 words per run.
//  Counts dropped words on overflow. Signals run completion once the last word has been handed over.
// PARAMETERS
//  SAMPLE_WIDTH     8   bits per input sample; AXI_WIDTH/SAMPLE_WIDTH (RATIO) must be a power of two, >=1
//  AXI_WIDTH        32  output word width; equals the DMA AXI data width
//  FIFO_DEPTH_LOG2  4   FIFO depth = 2**FIFO_DEPTH_LOG2 words
// PORTS
//  clk           in   1             single clock; same as the DMA AXI clock
//  rst           in   1             asynchronous, active-high reset
//  start         in   1             1-cycle pulse: clear and arm a run
//  words_cfg     in   16            words to deliver minus 1 (N+1 words per run)
//  sample_data   in   SAMPLE_WIDTH  input sample
//  sample_valid  in   1             sample strobe; no ready, never stalled
//  m_tdata       out  AXI_WIDTH     packed word
//  m_tvalid      out  1             word available
//  m_tready      in   1             consumer accept
//  m_tlast       out  1             high with the final word of the run
//  busy          out  1             run in progress (state != IDLE)
//  done          out  1             1-cycle pulse when the last word is accepted
//  overflow_cnt  out  16            words dropped since the last start; saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (async): state=IDLE; FIFO empty; lane_cnt=0; word_cnt=0.
//   Outputs after reset: m_tvalid=0, m_tlast=0, busy=0, done=0, overflow_cnt=0, m_tdata=0.
//  FSM:
//   IDLE  -start->  RUN
//   RUN   -last word pushed->  DRAIN
//   DRAIN -last word popped (m_tvalid&m_tready&m_tlast)->  IDLE; done=1 for that cycle
//  start in any state: synchronous restart. FIFO flushed; lane_cnt, word_cnt, overflow_cnt cleared; enter RUN.
//   A sample_valid in the start cycle is ignored.
//  Packing (RUN only):
//   Each sample_valid writes sample_data into lane lane_cnt of the shift word.
//   Little-endian: first sample lands in bits [SAMPLE_WIDTH-1:0].
//   lane_cnt wraps RATIO-1 -> 0. On the wrap, the completed word is pushed.
//   Samples arriving in IDLE or DRAIN are discarded.
//  Push rule:
//   A push is allowed when !full, or when full with a pop in the same cycle.
//   Otherwise the word is dropped, overflow_cnt increments (saturating), and word_cnt does not advance.
//   A dropped word is replaced by a later complete word, so every run still delivers exactly words_cfg+1 words.
//  word_cnt (17 bit) counts pushed words. The push with word_cnt==words_cfg marks that FIFO entry last and moves the FSM to DRAIN.
//  FIFO: show-ahead. m_tvalid=!empty. m_tdata and m_tlast come from the head entry.
//   Pop = m_tvalid&m_tready. Held data is stable while m_tvalid&!m_tready.
//  Latency: a sample completing a word at cycle n gives m_tvalid=1 at cycle n+1 (FIFO previously empty).
//  Throughput: 1 word/cycle; sustained input up to RATIO samples per output word without loss when m_tready=1.
//  words_cfg is sampled at start; changes mid-run have no effect.
//  Reset mid-run: immediate return to the reset state; partial word lost, no done pulse.
// CONFIGURATION
//  PACKER_TESTPAT_EN defined:
//   Adds input port testpat (1 bit). While testpat=1, sample_data is replaced by an internal SAMPLE_WIDTH counter.
//   The counter clears on start and increments per accepted sample (wraps modulo 2**SAMPLE_WIDTH).
//  PACKER_TESTPAT_EN undefined: no testpat port, no counter; samples pass unchanged.
// STRUCTURE
//  Package packer_pkg: typedef enum logic[1:0] {IDLE,RUN,DRAIN} packer_state_t;
//   function ratio(sample_w, axi_w) computing RATIO.
//  Sub-module packer_fifo:
//   sync show-ahead FIFO, width AXI_WIDTH+1 (data+last), depth 2**FIFO_DEPTH_LOG2.
//   Async reset; ports clk, rst, flush, push, din, pop, dout, full, empty.
// TESTING
//  T1:
//   SAMPLE_WIDTH=8, words_cfg=3, samples 0x00..0x0F back-to-back, m_tready=1
//   -> words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C; tlast on 4th; done 1 cycle later-equal; busy=0.
//  T2:
//   m_tready=0, FIFO_DEPTH_LOG2=2, words_cfg=9, 40 samples
//   -> 4 words held, 6 dropped, overflow_cnt=6; release tready, push 24 more samples
//   -> total 10 words, tlast on 10th.
//  T3:
//   Full FIFO with pop and push in the same cycle -> push accepted, overflow_cnt unchanged.
//  T4:
//   start pulse mid-run after 2 words and 1 lane filled -> FIFO empty next cycle, overflow_cnt=0;
//   the next 4 samples form word 0 of the new run.
//  T5:
//   rst asserted mid-DRAIN -> m_tvalid=0 and busy=0 with no clock edge needed, no done pulse.
//  T6 (PACKER_TESTPAT_EN):
//   testpat=1, words_cfg=1, 8 strobes -> 0x03020100, 0x07060504 regardless of sample_data.

Source files
------------

// File: rtl/axis_sample_packer_pkg.sv
// Shared types and helpers for the sample packer: FSM state encoding and lane-count sizing.
package packer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } packer_state_t;

    function automatic int ratio(input int sample_w, input int axi_w);
        return axi_w / sample_w;
    endfunction

    // Lane counter needs at least one bit even when a single sample fills a word.
    function automatic int lane_w(input int r);
        return (r > 1) ? $clog2(r) : 1;
    endfunction

endpackage

// File: rtl/axis_sample_packer_if.sv
// AXI4-stream style word channel between the packer and the DMA write path.
interface axis_sample_packer_if #(
    parameter int AXI_WIDTH = 32
) ();
    logic [AXI_WIDTH-1:0] tdata;
    logic                 tvalid;
    logic                 tready;
    logic                 tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_sample_packer_fifo.sv
// Synchronous show-ahead FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module packer_fifo #(
    parameter int WIDTH      = 33,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (DEPTH_LOG2+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_d = count_q + 1'b1;
            else if (!do_push && do_pop) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/axis_sample_packer.sv
// Packs narrow samples into AXI words and streams exactly words_cfg+1 words per run.
// Optional PACKER_TESTPAT_EN adds a testpat input that substitutes a counting pattern for sample_data.
//
// state | meaning
// IDLE  | no run armed; samples discarded
// RUN   | packing samples and pushing words
// DRAIN | last word pushed; waiting for it to be accepted
module axis_sample_packer
    import packer_pkg::*;
#(
    parameter int SAMPLE_WIDTH    = 8,
    parameter int AXI_WIDTH       = 32,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [15:0]             words_cfg,
    input  logic [SAMPLE_WIDTH-1:0] sample_data,
    input  logic                    sample_valid,
`ifdef PACKER_TESTPAT_EN
    input  logic                    testpat,
`endif
    axis_sample_packer_if.master    m_axis,
    output logic                    busy,
    output logic                    done,
    output logic [15:0]             overflow_cnt
);
    localparam int RATIO = ratio(SAMPLE_WIDTH, AXI_WIDTH);
    localparam int LW    = lane_w(RATIO);

    packer_state_t         state_q, state_d;
    logic [LW-1:0]         lane_q, lane_d;
    logic [16:0]           word_cnt_q, word_cnt_d;
    logic [15:0]           cfg_q, cfg_d;
    logic [AXI_WIDTH-1:0]  shift_q, shift_d;
    logic [15:0]           ovf_q, ovf_d;
    logic                  done_q, done_d;
    logic [SAMPLE_WIDTH-1:0] sample_in;
    logic [AXI_WIDTH-1:0]  word_next;
    logic                  fifo_push, fifo_last, fifo_pop, fifo_full, fifo_empty;
    logic [AXI_WIDTH:0]    fifo_dout;

`ifdef PACKER_TESTPAT_EN
    logic [SAMPLE_WIDTH-1:0] tp_q, tp_d;
    assign sample_in = testpat ? tp_q : sample_data;
`else
    assign sample_in = sample_data;
`endif

    assign fifo_pop = !fifo_empty && m_axis.tready;

    always_comb begin
        state_d    = state_q;
        lane_d     = lane_q;
        word_cnt_d = word_cnt_q;
        cfg_d      = cfg_q;
        shift_d    = shift_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;
        fifo_push  = 1'b0;
        fifo_last  = 1'b0;
        word_next  = shift_q;
`ifdef PACKER_TESTPAT_EN
        tp_d       = tp_q;
`endif
        if (start) begin
            state_d    = RUN;
            lane_d     = '0;
            word_cnt_d = '0;
            cfg_d      = words_cfg;
            ovf_d      = '0;
`ifdef PACKER_TESTPAT_EN
            tp_d       = '0;
`endif
        end else begin
            if (fifo_pop && fifo_dout[AXI_WIDTH]) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            if (state_q == RUN && sample_valid) begin
                word_next[lane_q*SAMPLE_WIDTH +: SAMPLE_WIDTH] = sample_in;
                shift_d = word_next;
`ifdef PACKER_TESTPAT_EN
                tp_d    = tp_q + 1'b1;
`endif
                if (lane_q == LW'(RATIO-1)) begin
                    lane_d = '0;
                    if (!fifo_full || fifo_pop) begin
                        fifo_push  = 1'b1;
                        word_cnt_d = word_cnt_q + 1'b1;
                        if (word_cnt_q == {1'b0, cfg_q}) begin
                            fifo_last = 1'b1;
                            state_d   = DRAIN;
                        end
                    end else if (ovf_q != 16'hFFFF) begin
                        ovf_d = ovf_q + 1'b1;
                    end
                end else begin
                    lane_d = lane_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            lane_q     <= '0;
            word_cnt_q <= '0;
            cfg_q      <= '0;
            shift_q    <= '0;
            ovf_q      <= '0;
            done_q     <= 1'b0;
`ifdef PACKER_TESTPAT_EN
            tp_q       <= '0;
`endif
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            word_cnt_q <= word_cnt_d;
            cfg_q      <= cfg_d;
            shift_q    <= shift_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
`ifdef PACKER_TESTPAT_EN
            tp_q       <= tp_d;
`endif
        end
    end

    packer_fifo #(
        .WIDTH      (AXI_WIDTH + 1),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (start),
        .push  (fifo_push),
        .din   ({fifo_last, word_next}),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Gate the head entry so an empty FIFO always presents zeros.
    assign m_axis.tvalid = !fifo_empty;
    assign m_axis.tdata  = fifo_empty ? '0 : fifo_dout[AXI_WIDTH-1:0];
    assign m_axis.tlast  = !fifo_empty && fifo_dout[AXI_WIDTH];
    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign overflow_cnt  = ovf_q;

endmodule

// File: tb/tb_axis_sample_packer.sv
// Self-checking bench for axis_sample_packer against a queue-based reference model.
module tb_axis_sample_packer;
    localparam int SW    = 8;
    localparam int AW    = 32;
    localparam int DL    = 2;
    localparam int DEPTH = 1 << DL;
    localparam int RATIO = AW / SW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [15:0]   words_cfg = '0;
    logic [SW-1:0] sample_data = '0;
    logic          sample_valid = 1'b0;
    logic          busy, done;
    logic [15:0]   overflow_cnt;
`ifdef PACKER_TESTPAT_EN
    logic          testpat = 1'b0;
`endif

    axis_sample_packer_if #(.AXI_WIDTH(AW)) m_axis ();

    axis_sample_packer #(
        .SAMPLE_WIDTH    (SW),
        .AXI_WIDTH       (AW),
        .FIFO_DEPTH_LOG2 (DL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .words_cfg    (words_cfg),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
`ifdef PACKER_TESTPAT_EN
        .testpat      (testpat),
`endif
        .m_axis       (m_axis.master),
        .busy         (busy),
        .done         (done),
        .overflow_cnt (overflow_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] data;
        bit            last;
    } ent_t;

    ent_t         mq[$];
    logic [SW-1:0] partial[$];
    int           pushed, mcfg, mstate, movf, tpc, nacc;
    bit           mdone;
    int           checks = 0;
    int           failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        partial.delete();
        pushed = 0; mcfg = 0; mstate = 0; movf = 0; tpc = 0; mdone = 0;
    endtask

    // One clock of the reference: pop decided on pre-edge occupancy, then the sample rules.
    task automatic model_cycle(input bit st, input logic [15:0] cfg_in, input bit v,
                               input logic [SW-1:0] d, input bit rdy, input bit tp);
        int   occ;
        bit   do_pop, popped_last;
        ent_t e;
        mdone = 0;
        if (st) begin
            mq.delete();
            partial.delete();
            pushed = 0; mcfg = int'(cfg_in); movf = 0; mstate = 1; tpc = 0;
            return;
        end
        occ         = mq.size();
        do_pop      = rdy && (occ > 0);
        popped_last = do_pop && mq[0].last;
        if (mstate == 1 && v) begin
            partial.push_back(tp ? SW'(tpc) : d);
            tpc = (tpc + 1) % (1 << SW);
            if (partial.size() == RATIO) begin
                e.data = '0;
                for (int i = 0; i < RATIO; i++) e.data |= AW'(partial[i]) << (SW * i);
                partial.delete();
                if (occ < DEPTH || do_pop) begin
                    e.last = (pushed == mcfg);
                    pushed++;
                    mq.push_back(e);
                    if (e.last) mstate = 2;
                end else if (movf < 65535) begin
                    movf++;
                end
            end
        end
        if (do_pop) void'(mq.pop_front());
        if (popped_last) begin
            mdone  = 1;
            mstate = 0;
        end
    endtask

    task automatic check_outputs();
        chk("tvalid", m_axis.tvalid, mq.size() > 0);
        if (mq.size() > 0) begin
            chk("tdata", m_axis.tdata, mq[0].data);
            chk("tlast", m_axis.tlast, mq[0].last);
        end
        chk("busy", busy, mstate != 0);
        chk("done", done, mdone);
        chk("overflow_cnt", overflow_cnt, movf);
    endtask

    // Called at posedge+1; drives one cycle of inputs and checks after the next edge.
    task automatic step(input bit st, input logic [15:0] cfg_in, input bit v,
                        input logic [SW-1:0] d, input bit rdy, input bit tp = 1'b0);
        start        = st;
        words_cfg    = cfg_in;
        sample_valid = v;
        sample_data  = d;
        m_axis.tready = rdy;
`ifdef PACKER_TESTPAT_EN
        testpat      = tp;
`endif
        if (!st && m_axis.tvalid && rdy) nacc++;
        model_cycle(st, cfg_in, v, d, rdy, tp);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic drain(input int budget, input int rdy_pct);
        int n = 0;
        while ((mstate != 0 || mq.size() > 0) && n < budget) begin
            step(0, 16'h0, $urandom_range(0, 1), SW'($urandom), $urandom_range(0, 99) < rdy_pct);
            n++;
        end
        chk("drain_bounded_busy", busy, 1'b0);
    endtask

    initial begin
        model_reset();
        m_axis.tready = 1'b0;
        nacc = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", m_axis.tvalid, 1'b0);
        chk("rst_tlast", m_axis.tlast, 1'b0);
        chk("rst_tdata", m_axis.tdata, 0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ovf", overflow_cnt, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // T1: 16 back-to-back samples, 4 words, always ready
        step(1, 16'd3, 0, 0, 1);
        for (int i = 0; i < 16; i++) begin
            step(0, 16'd3, 1, SW'(i), 1);
            if (i == 3) begin
                chk("t1_latency_tvalid", m_axis.tvalid, 1'b1);
                chk("t1_word0", m_axis.tdata, 32'h03020100);
            end
        end
        chk("t1_word3", m_axis.tdata, 32'h0F0E0D0C);
        chk("t1_tlast", m_axis.tlast, 1'b1);
        step(0, 16'd3, 0, 0, 1);
        chk("t1_done", done, 1'b1);
        chk("t1_busy", busy, 1'b0);
        step(0, 16'd3, 0, 0, 1);
        chk("t1_done_pulse", done, 1'b0);

        // T2: stalled consumer overflows, then releases
        nacc = 0;
        step(1, 16'd9, 0, 0, 0);
        for (int i = 0; i < 40; i++) step(0, 16'd9, 1, SW'($urandom), 0);
        chk("t2_ovf", overflow_cnt, 16'd6);
        for (int i = 0; i < 24; i++) step(0, 16'd9, 1, SW'($urandom), 1);
        drain(40, 100);
        chk("t2_words", nacc, 10);
        chk("t2_ovf_final", overflow_cnt, 16'd6);

        // T3: one drop, then a push into a full FIFO with a simultaneous pop
        step(1, 16'd20, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 16'd20, 1, SW'($urandom), 0);
        chk("t3_ovf_drop", overflow_cnt, 16'd1);
        for (int i = 0; i < 3; i++) step(0, 16'd20, 1, SW'($urandom), 0);
        step(0, 16'd20, 1, SW'($urandom), 1);
        chk("t3_ovf_unchanged", overflow_cnt, 16'd1);
        chk("t3_tvalid", m_axis.tvalid, 1'b1);

        // T4: restart mid-run with 2 words queued and 1 lane filled
        step(1, 16'd7, 0, 0, 0);
        chk("t4_ovf_clear", overflow_cnt, 16'd0);
        for (int i = 0; i < 9; i++) step(0, 16'd7, 1, SW'($urandom), 0);
        step(1, 16'd7, 1, 8'hEE, 0);
        chk("t4_empty", m_axis.tvalid, 1'b0);
        chk("t4_ovf", overflow_cnt, 16'd0);
        for (int i = 0; i < 4; i++) step(0, 16'd7, 1, SW'(8'hA0 + i), 0);
        chk("t4_word0", m_axis.tdata, 32'hA3A2A1A0);
        for (int i = 0; i < 60; i++)
            step(0, 16'd7, $urandom_range(0, 1), SW'($urandom), $urandom_range(0, 1));
        drain(200, 50);

        // T5: async reset while draining
        step(1, 16'd1, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 16'd1, 1, SW'($urandom), 0);
        chk("t5_in_drain", busy, 1'b1);
        #3 rst = 1'b1;
        #1;
        chk("t5_tvalid", m_axis.tvalid, 1'b0);
        chk("t5_busy", busy, 1'b0);
        chk("t5_done", done, 1'b0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_outputs();

        // Randomized runs
        for (int r = 0; r < 12; r++) begin
            int cfg = $urandom_range(0, 12);
            int vp  = $urandom_range(30, 100);
            int rp  = $urandom_range(20, 100);
            step(1, 16'(cfg), 0, 0, 1);
            for (int i = 0; i < 40; i++)
                step(0, 16'($urandom), $urandom_range(0, 99) < vp, SW'($urandom),
                     $urandom_range(0, 99) < rp);
            drain(1000, rp);
        end

`ifdef PACKER_TESTPAT_EN
        // T6: internal test pattern
        step(1, 16'd1, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++) begin
            step(0, 16'd1, 1, SW'($urandom), 0, 1);
            if (i == 3) chk("t6_word0", m_axis.tdata, 32'h03020100);
        end
        step(0, 16'd1, 0, 0, 1, 1);
        chk("t6_word1", m_axis.tdata, 32'h07060504);
        drain(20, 100);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
